// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write-port select path.
package regfile_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic {IDLE, GRANT} grant_state_e;

    typedef logic [SEL_W-1:0] reg_sel_t;

endpackage

// File: rtl/rr_priority_encoder.sv
// Rotating priority encoder: first set request bit at or above start, wrapping 7->0.
module rr_priority_encoder
    import regfile_pkg::*;
(
    input  logic [NUM_REQ-1:0] request,
    input  logic [SEL_W-1:0]   start,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0] rot;
    reg_sel_t           off;

    // Rotate right by start so the search origin lands at bit 0; the SEL_W-bit
    // index sum wraps naturally modulo NUM_REQ.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rot[i] = request[SEL_W'(i) + start];
        end
    end

    always_comb begin
        found = 1'b0;
        off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = SEL_W'(i);
            end
        end
    end

    assign idx = off + start;

endmodule

// File: rtl/rr_grant_encoder_8_3.sv
// Round-robin 8->3 grant encoder with sticky valid/ready grants and a one-hot copy.
module rr_grant_encoder_8_3
    import regfile_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [NUM_REQ-1:0] request,
    input  logic               grant_ready,
    output logic               grant_valid,
    output logic [SEL_W-1:0]   grant_sel,
    output logic [NUM_REQ-1:0] grant_onehot
);

    grant_state_e       state, state_nxt;
    reg_sel_t           ptr, ptr_nxt;
    reg_sel_t           search_start;
    logic               found;
    reg_sel_t           winner;
    logic               valid_nxt;
    reg_sel_t           sel_nxt;
    logic [NUM_REQ-1:0] onehot_nxt;

    // On an accept the pointer update has not landed yet, so search from
    // grant_sel+1 directly to keep back-to-back grants fair.
    assign search_start = (state == GRANT) ? reg_sel_t'(grant_sel + 1'b1) : ptr;

    rr_priority_encoder u_prio (
        .request (request),
        .start   (search_start),
        .found   (found),
        .idx     (winner)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            ptr          <= '0;
            grant_valid  <= 1'b0;
            grant_sel    <= '0;
            grant_onehot <= '0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            grant_valid  <= valid_nxt;
            grant_sel    <= sel_nxt;
            grant_onehot <= onehot_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        valid_nxt  = grant_valid;
        sel_nxt    = grant_sel;
        onehot_nxt = grant_onehot;
        unique case (state)
            IDLE: begin
                if (enable && found) begin
                    state_nxt  = GRANT;
                    valid_nxt  = 1'b1;
                    sel_nxt    = winner;
                    onehot_nxt = NUM_REQ'(1) << winner;
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    ptr_nxt = reg_sel_t'(grant_sel + 1'b1);
                    if (enable && found) begin
                        valid_nxt  = 1'b1;
                        sel_nxt    = winner;
                        onehot_nxt = NUM_REQ'(1) << winner;
                    end else begin
                        // grant_sel intentionally keeps its last value
                        state_nxt  = IDLE;
                        valid_nxt  = 1'b0;
                        onehot_nxt = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rr_grant_encoder_8_3.sv
// Directed bench for rr_grant_encoder_8_3 with hand-computed expectations.
module tb_rr_grant_encoder_8_3;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [7:0] request;
    logic       grant_ready;
    logic       grant_valid;
    logic [2:0] grant_sel;
    logic [7:0] grant_onehot;

    int checks = 0;
    int errors = 0;

    rr_grant_encoder_8_3 dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .request      (request),
        .grant_ready  (grant_ready),
        .grant_valid  (grant_valid),
        .grant_sel    (grant_sel),
        .grant_onehot (grant_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic v, input logic [2:0] s,
                             input logic [7:0] oh);
        chk({tag, "_valid"},  {7'b0, grant_valid}, {7'b0, v});
        chk({tag, "_sel"},    {5'b0, grant_sel},   {5'b0, s});
        chk({tag, "_onehot"}, grant_onehot,        oh);
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        request     = 8'h00;
        grant_ready = 1'b0;
        #3;
        chk_grant("reset", 1'b0, 3'd0, 8'h00);
        step();
        step();
        reset_n = 1'b1;

        // single request, latency 1, then idle once it drops
        enable = 1'b1; request = 8'h04; grant_ready = 1'b1;
        step();
        chk_grant("single", 1'b1, 3'd2, 8'h04);
        request = 8'h00;
        step();
        chk_grant("single_idle", 1'b0, 3'd2, 8'h00);

        // ptr is now 3; grant, then reset asynchronously mid-GRANT
        request = 8'hFF;
        step();
        chk_grant("pre_reset", 1'b1, 3'd3, 8'h08);
        #2;
        reset_n = 1'b0;
        #1;
        chk_grant("async_reset", 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;

        // all requesting: 0..7 then wrap to 0, back to back
        for (int i = 0; i <= 8; i++) begin
            step();
            chk_grant("rr_all", 1'b1, 3'(i), 8'h01 << (i % 8));
        end

        // backpressure: sel=5 held while request/enable change
        request = 8'h20;
        step();
        chk_grant("bp_issue", 1'b1, 3'd5, 8'h20);
        grant_ready = 1'b0; request = 8'h01;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) enable = 1'b0;
            step();
            chk_grant("bp_hold", 1'b1, 3'd5, 8'h20);
        end
        enable = 1'b1; grant_ready = 1'b1;
        step();
        chk_grant("bp_release", 1'b1, 3'd0, 8'h01);

        // wrap: grant 6, then 7, then 0
        request = 8'h40;
        step();
        chk_grant("wrap6", 1'b1, 3'd6, 8'h40);
        request = 8'h81;
        step();
        chk_grant("wrap7", 1'b1, 3'd7, 8'h80);
        step();
        chk_grant("wrap0", 1'b1, 3'd0, 8'h01);

        // enable low: accept drops to IDLE, no new grant; ptr becomes 1
        enable = 1'b0; request = 8'hFF;
        step();
        chk_grant("dis_idle", 1'b0, 3'd0, 8'h00);
        step();
        chk_grant("dis_stay", 1'b0, 3'd0, 8'h00);
        enable = 1'b1;
        step();
        chk_grant("en_ptr", 1'b1, 3'd1, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
